pe_tile_sequencer: RTL and testbench
====================================

# pe_tile_sequencer

Control stage directly upstream of `processing_element`. It accepts one dot-product tile command at a time and expands it into the PE instruction stream CLR → MAC×N → RND (optional) → OUT. It reads vector and matrix operands from two 1-cycle-latency SRAMs and aligns them with each MAC instruction. It also captures the PE's `vector_output` after OUT and returns it as a result with a valid pulse.

## Interface
Parameters:
- `ADDR_W`, 10, SRAM word-address width (vector and matrix SRAMs).
- `LEN_W`, 8, width of the MAC count field; N ranges 0..2^LEN_W-1.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_len`  in  LEN_W  number of MACs N.
- `cmd_mode`  in  `PE_MODE_BITWIDTH`  lane mode forwarded on every instruction (0=4×8b, 1=2×16b, other=1×32b).
- `cmd_shift`  in  `PE_VALUE_BITWIDTH`  RND shift; 0 suppresses the RND instruction.
- `cmd_vec_base`, `cmd_mat_base`  in  ADDR_W  first operand addresses.
- `vec_rd_en`, `mat_rd_en`  out  1  SRAM read strobes.
- `vec_rd_addr`, `mat_rd_addr`  out  ADDR_W  SRAM addresses.
- `vec_rd_data`, `mat_rd_data`  in  `PE_INPUT_BITWIDTH`  SRAM data, valid the cycle after the strobe.
- `pe_inst`  out  pe_inst_t  instruction to PE.
- `pe_inst_valid`  out  1  instruction valid.
- `pe_vector_input`, `pe_matrix_input`  out  `PE_INPUT_BITWIDTH`  operands to PE.
- `pe_vector_output`  in  `PE_OUTPUT_BITWIDTH`  PE result.
- `result_valid`  out  1  one-cycle pulse.
- `result_data`  out  `PE_OUTPUT_BITWIDTH`  captured result.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Instruction encodings:
  - RND: opcode=`PE_RND_OPCODE`, value=shift.
  - All others: opcode=`PE_OP_OPCODE`, value ∈ {`PE_CLR_VALUE`, `PE_MAC_VALUE`, `PE_OUT_VALUE`}.
  - mode=latched cmd_mode on every instruction.
- Command acceptance: on cmd_valid&&cmd_ready, latch all cmd fields, clear MAC counter k=0, go to CLR.
- FSM (one state per cycle unless noted):
  - IDLE → CLR on accept.
  - CLR → MAC if N>0; else RND if shift≠0; else OUT.
  - MAC stays for N cycles, k=0..N-1. Exits when k==N-1 to RND (shift≠0) or OUT.
  - RND → OUT.
  - OUT → WAIT.
  - WAIT → CAP.
  - CAP → IDLE.
- Read issue: in MAC state, vec_rd_en=mat_rd_en=1, vec_rd_addr=vec_base+k, mat_rd_addr=mat_base+k. Addresses wrap modulo 2^ADDR_W. Strobes are 0 in all other states.
- Stage register: each FSM state except IDLE/WAIT/CAP writes its instruction into a one-entry stage register. The stage register drives pe_inst/pe_inst_valid on the following cycle.
- Operand alignment: pe_vector_input/pe_matrix_input pass vec_rd_data/mat_rd_data through combinationally when the staged instruction is MAC. They are 0 otherwise.
- Result capture: in CAP, result_data<=pe_vector_output. result_valid pulses for exactly the cycle after CAP. result_data holds until the next capture.
- Width rules: k counts in LEN_W bits and never overflows, because exit occurs at k==N-1.
- No backpressure: the PE consumes one instruction per cycle.

## Timing
- Accept edge = cycle 0. FSM is in CLR during cycle 1.
- pe_inst_valid timeline for N MACs, shift≠0:
  - CLR in cycle 2.
  - MAC k in cycle 3+k.
  - RND in cycle 3+N.
  - OUT in cycle 4+N.
- With shift=0, OUT moves to cycle 3+N and all later events shift one cycle earlier.
- SRAM strobe for MAC k occurs in cycle 2+k. Data is consumed in cycle 3+k.
- PE output register updates at the end of the OUT cycle. CAP samples it in the cycle after the OUT cycle. result_valid and busy=0 occur in the cycle after CAP. cmd_ready rises in that same cycle.
- Instruction slots are contiguous; there is never a bubble between CLR and OUT.
- Reset values: cmd_ready=0 while rst_n=0 and 1 from the first cycle after reset. All of the following are 0: pe_inst_valid, pe_inst, read strobes/addresses, PE operands, result_valid, result_data, busy.
- Reset mid-command: FSM→IDLE, stage register cleared, and no further instruction or result is emitted. The PE is reset by the same rst_n.
- cmd_valid while busy is ignored. The command is not latched, and the source must hold it until cmd_ready.

## Test plan
- Mode 2, N=3, shift=0, vec=[2,3,4], mat=[5,6,7] at base 0 → instructions CLR,MAC,MAC,MAC,OUT in cycles 2–6; result_data=56, result_valid pulse in cycle 8.
- Mode 0, N=2, shift=1, lanes vec={1,2,3,4}, mat={10,10,10,10} per word → RND value=1 in cycle 5; result lanes {10,20,30,40}.
- N=0, shift=0 → CLR then OUT back-to-back with no read strobes; result_data=0.
- vec_base=1023, mat_base=1022, N=3 (ADDR_W=10) → vec addresses 1023,0,1; mat addresses 1022,1023,0.
- rst_n low in cycle 4 of an N=10 command → pe_inst_valid=0 from next cycle, no result_valid, cmd_ready=1 after release; a new command then runs normally.
- cmd_valid held high through a busy command with changing fields → only the field values present at the cmd_ready cycle are accepted; two results are produced back-to-back, separated by exactly one IDLE cycle.

Source files
------------

// File: rtl/pe_tile_sequencer.sv
// pe_tile_sequencer: expands one dot-product tile command into the PE
// instruction stream CLR -> MAC x N -> RND (optional) -> OUT. It fetches
// operands from the vector/matrix SRAMs so they line up with each MAC and
// captures the PE result after OUT.

`timescale 1ns/1ps

package pe_pkg;
  localparam int PE_MODE_BITWIDTH    = 2;
  localparam int PE_VALUE_BITWIDTH   = 8;
  localparam int PE_OPCODE_BITWIDTH  = 2;
  localparam int PE_INPUT_BITWIDTH   = 32;
  localparam int PE_OUTPUT_BITWIDTH  = 32;

  localparam logic [PE_OPCODE_BITWIDTH-1:0] PE_OP_OPCODE  = 2'd0;
  localparam logic [PE_OPCODE_BITWIDTH-1:0] PE_RND_OPCODE = 2'd1;

  localparam logic [PE_VALUE_BITWIDTH-1:0] PE_CLR_VALUE = 8'd1;
  localparam logic [PE_VALUE_BITWIDTH-1:0] PE_MAC_VALUE = 8'd2;
  localparam logic [PE_VALUE_BITWIDTH-1:0] PE_OUT_VALUE = 8'd3;

  typedef struct packed {
    logic [PE_OPCODE_BITWIDTH-1:0] opcode;
    logic [PE_MODE_BITWIDTH-1:0]   mode;
    logic [PE_VALUE_BITWIDTH-1:0]  value;
  } pe_inst_t;
endpackage

module pe_tile_sequencer
  import pe_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [LEN_W-1:0]              cmd_len,
  input  logic [PE_MODE_BITWIDTH-1:0]   cmd_mode,
  input  logic [PE_VALUE_BITWIDTH-1:0]  cmd_shift,
  input  logic [ADDR_W-1:0]             cmd_vec_base,
  input  logic [ADDR_W-1:0]             cmd_mat_base,
  output logic                          vec_rd_en,
  output logic [ADDR_W-1:0]             vec_rd_addr,
  input  logic [PE_INPUT_BITWIDTH-1:0]  vec_rd_data,
  output logic                          mat_rd_en,
  output logic [ADDR_W-1:0]             mat_rd_addr,
  input  logic [PE_INPUT_BITWIDTH-1:0]  mat_rd_data,
  output pe_inst_t                      pe_inst,
  output logic                          pe_inst_valid,
  output logic [PE_INPUT_BITWIDTH-1:0]  pe_vector_input,
  output logic [PE_INPUT_BITWIDTH-1:0]  pe_matrix_input,
  input  logic [PE_OUTPUT_BITWIDTH-1:0] pe_vector_output,
  output logic                          result_valid,
  output logic [PE_OUTPUT_BITWIDTH-1:0] result_data,
  output logic                          busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_MAC, S_RND, S_OUT, S_WAIT, S_CAP
  } state_t;

  state_t                         r_state;
  state_t                         w_next_state;
  logic [LEN_W-1:0]               r_len;
  logic [PE_MODE_BITWIDTH-1:0]    r_mode;
  logic [PE_VALUE_BITWIDTH-1:0]   r_shift;
  logic [ADDR_W-1:0]              r_vec_base;
  logic [ADDR_W-1:0]              r_mat_base;
  logic [LEN_W-1:0]               r_k;
  logic                           r_stage_valid;
  pe_inst_t                       r_stage_inst;
  logic                           r_result_valid;
  logic [PE_OUTPUT_BITWIDTH-1:0]  r_result_data;

  logic                           w_accept;
  logic                           w_k_last;
  logic                           w_stage_load;
  pe_inst_t                       w_stage_inst;
  logic                           w_rd_en;
  logic                           w_stage_is_mac;

  // Ready is forced low while reset is held so no command slips in then.
  assign cmd_ready = rst_n && (r_state == S_IDLE);
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_k_last  = (r_k == r_len - LEN_W'(1));
  assign busy      = (r_state != S_IDLE);

  // Next-state decode plus the instruction each state hands to the stage register.
  always_comb begin
    // NOTE: every signal gets a default first so no latch can be inferred.
    w_next_state = r_state;
    w_stage_load = 1'b0;
    w_stage_inst = '0;
    w_rd_en      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = S_CLR;
      end
      S_CLR: begin
        w_stage_load = 1'b1;
        w_stage_inst = '{opcode: PE_OP_OPCODE, mode: r_mode, value: PE_CLR_VALUE};
        if (r_len != '0)        w_next_state = S_MAC;
        else if (r_shift != '0) w_next_state = S_RND;
        else                    w_next_state = S_OUT;
      end
      S_MAC: begin
        w_stage_load = 1'b1;
        w_rd_en      = 1'b1;
        w_stage_inst = '{opcode: PE_OP_OPCODE, mode: r_mode, value: PE_MAC_VALUE};
        if (w_k_last) w_next_state = (r_shift != '0) ? S_RND : S_OUT;
      end
      S_RND: begin
        w_stage_load = 1'b1;
        w_stage_inst = '{opcode: PE_RND_OPCODE, mode: r_mode, value: r_shift};
        w_next_state = S_OUT;
      end
      S_OUT: begin
        w_stage_load = 1'b1;
        w_stage_inst = '{opcode: PE_OP_OPCODE, mode: r_mode, value: PE_OUT_VALUE};
        w_next_state = S_WAIT;
      end
      S_WAIT:  w_next_state = S_CAP;
      S_CAP:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignment so all flops update together.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Latch the command fields on acceptance; they stay stable for the whole tile.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_len      <= '0;
      r_mode     <= '0;
      r_shift    <= '0;
      r_vec_base <= '0;
      r_mat_base <= '0;
    end else if (w_accept) begin
      r_len      <= cmd_len;
      r_mode     <= cmd_mode;
      r_shift    <= cmd_shift;
      r_vec_base <= cmd_vec_base;
      r_mat_base <= cmd_mat_base;
    end
  end

  // MAC index: cleared on accept, advances once per MAC cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)               r_k <= '0;
    else if (w_accept)        r_k <= '0;
    else if (r_state == S_MAC) r_k <= r_k + LEN_W'(1);
  end

  // One-entry stage register delays each instruction by a cycle so it meets the SRAM data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stage_valid <= 1'b0;
      r_stage_inst  <= '0;
    end else begin
      r_stage_valid <= w_stage_load;
      r_stage_inst  <= w_stage_load ? w_stage_inst : '0;
    end
  end

  // Capture the PE output in CAP and pulse valid for the following cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result_valid <= 1'b0;
      r_result_data  <= '0;
    end else begin
      r_result_valid <= (r_state == S_CAP);
      if (r_state == S_CAP) r_result_data <= pe_vector_output;
    end
  end

  // Read addresses wrap naturally in ADDR_W bits.
  assign vec_rd_en   = w_rd_en;
  assign mat_rd_en   = w_rd_en;
  assign vec_rd_addr = w_rd_en ? (r_vec_base + ADDR_W'(r_k)) : '0;
  assign mat_rd_addr = w_rd_en ? (r_mat_base + ADDR_W'(r_k)) : '0;

  assign w_stage_is_mac  = r_stage_valid && (r_stage_inst.opcode == PE_OP_OPCODE)
                           && (r_stage_inst.value == PE_MAC_VALUE);
  assign pe_inst         = r_stage_inst;
  assign pe_inst_valid   = r_stage_valid;
  assign pe_vector_input = w_stage_is_mac ? vec_rd_data : '0;
  assign pe_matrix_input = w_stage_is_mac ? mat_rd_data : '0;
  assign result_valid    = r_result_valid;
  assign result_data     = r_result_data;

endmodule

// File: tb/tb_pe_tile_sequencer.sv
// Bench for pe_tile_sequencer: SRAM and PE stand-ins, directed scenarios
// and randomized commands, each cycle compared with the expected schedule.

`timescale 1ns/1ps

module tb_pe_tile_sequencer;
  import pe_pkg::*;

  localparam int ADDR_W = 10;
  localparam int LEN_W  = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic                          cmd_valid;
  logic                          cmd_ready;
  logic [LEN_W-1:0]              cmd_len;
  logic [PE_MODE_BITWIDTH-1:0]   cmd_mode;
  logic [PE_VALUE_BITWIDTH-1:0]  cmd_shift;
  logic [ADDR_W-1:0]             cmd_vec_base;
  logic [ADDR_W-1:0]             cmd_mat_base;
  logic                          vec_rd_en, mat_rd_en;
  logic [ADDR_W-1:0]             vec_rd_addr, mat_rd_addr;
  logic [PE_INPUT_BITWIDTH-1:0]  vec_rd_data, mat_rd_data;
  pe_inst_t                      pe_inst;
  logic                          pe_inst_valid;
  logic [PE_INPUT_BITWIDTH-1:0]  pe_vector_input, pe_matrix_input;
  logic [PE_OUTPUT_BITWIDTH-1:0] pe_vector_output;
  logic                          result_valid;
  logic [PE_OUTPUT_BITWIDTH-1:0] result_data;
  logic                          busy;

  logic [31:0] vec_mem [DEPTH];
  logic [31:0] mat_mem [DEPTH];
  logic [31:0] pe_acc, pe_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pe_tile_sequencer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_mode(cmd_mode), .cmd_shift(cmd_shift),
    .cmd_vec_base(cmd_vec_base), .cmd_mat_base(cmd_mat_base),
    .vec_rd_en(vec_rd_en), .vec_rd_addr(vec_rd_addr), .vec_rd_data(vec_rd_data),
    .mat_rd_en(mat_rd_en), .mat_rd_addr(mat_rd_addr), .mat_rd_data(mat_rd_data),
    .pe_inst(pe_inst), .pe_inst_valid(pe_inst_valid),
    .pe_vector_input(pe_vector_input), .pe_matrix_input(pe_matrix_input),
    .pe_vector_output(pe_vector_output),
    .result_valid(result_valid), .result_data(result_data), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int lane_w(input logic [1:0] mode);
    return (mode == 2'd0) ? 8 : (mode == 2'd1) ? 16 : 32;
  endfunction

  // Lane-wise multiply-accumulate with wrap in each lane.
  function automatic logic [31:0] lane_mac(input logic [31:0] acc, input logic [31:0] v,
                                           input logic [31:0] m, input logic [1:0] mode);
    int lw;
    logic [63:0] mask, a, x, y, s, r;
    lw = lane_w(mode);
    mask = (64'd1 << lw) - 64'd1;
    r = '0;
    for (int l = 0; l < 32 / lw; l++) begin
      a = (64'(acc) >> (l * lw)) & mask;
      x = (64'(v) >> (l * lw)) & mask;
      y = (64'(m) >> (l * lw)) & mask;
      s = (a + x * y) & mask;
      r = r | (s << (l * lw));
    end
    return r[31:0];
  endfunction

  // Lane-wise round-half-up right shift.
  function automatic logic [31:0] lane_rnd(input logic [31:0] acc, input logic [7:0] sh,
                                           input logic [1:0] mode);
    int lw;
    logic [63:0] mask, a, r;
    lw = lane_w(mode);
    mask = (64'd1 << lw) - 64'd1;
    r = '0;
    for (int l = 0; l < 32 / lw; l++) begin
      a = (64'(acc) >> (l * lw)) & mask;
      if (sh != 8'd0) a = ((a + (64'd1 << (sh - 8'd1))) >> sh) & mask;
      r = r | (a << (l * lw));
    end
    return r[31:0];
  endfunction

  // Expected tile result straight from memory contents and the command.
  function automatic logic [31:0] model_result(input int n, input int sh, input int md,
                                               input int vb, input int mb);
    logic [31:0] acc;
    acc = '0;
    for (int k = 0; k < n; k++)
      acc = lane_mac(acc, vec_mem[(vb + k) % DEPTH], mat_mem[(mb + k) % DEPTH], 2'(md));
    if (sh != 0) acc = lane_rnd(acc, 8'(sh), 2'(md));
    return acc;
  endfunction

  // 1-cycle-latency SRAM stand-ins.
  always @(posedge clk) begin
    if (vec_rd_en) vec_rd_data <= vec_mem[vec_rd_addr];
    if (mat_rd_en) mat_rd_data <= mat_mem[mat_rd_addr];
  end

  // Behavioural PE: executes one instruction per cycle, OUT updates its output register.
  always @(posedge clk) begin
    if (!rst_n) begin
      pe_acc <= '0;
      pe_out <= '0;
    end else if (pe_inst_valid) begin
      if (pe_inst.opcode == PE_RND_OPCODE) pe_acc <= lane_rnd(pe_acc, pe_inst.value, pe_inst.mode);
      else if (pe_inst.value == PE_CLR_VALUE) pe_acc <= '0;
      else if (pe_inst.value == PE_MAC_VALUE)
        pe_acc <= lane_mac(pe_acc, pe_vector_input, pe_matrix_input, pe_inst.mode);
      else if (pe_inst.value == PE_OUT_VALUE) pe_out <= pe_acc;
    end
  end
  assign pe_vector_output = pe_out;

  task automatic drive_cmd(input int n, input int sh, input int md, input int vb, input int mb);
    cmd_valid    = 1'b1;
    cmd_len      = LEN_W'(n);
    cmd_shift    = 8'(sh);
    cmd_mode     = 2'(md);
    cmd_vec_base = ADDR_W'(vb);
    cmd_mat_base = ADDR_W'(mb);
  endtask

  // Starts in an IDLE cycle at a negedge; returns at the negedge of the
  // cycle where result_valid is expected (DUT idle again).
  task automatic run_cmd(input int n, input int sh, input int md, input int vb,
                         input int mb, input bit hold);
    int last, idx;
    bit inst_v, rd_v, mac_v;
    logic [31:0] exp_res;
    pe_inst_t exp_inst;
    last    = (sh != 0) ? 4 + n : 3 + n;
    exp_res = model_result(n, sh, md, vb, mb);
    check("ready_before_cmd", 64'(cmd_ready), 64'd1);
    drive_cmd(n, sh, md, vb, mb);
    @(posedge clk);
    for (int c = 1; c <= last + 2; c++) begin
      @(negedge clk);
      if (!hold) cmd_valid = 1'b0;
      else if (c < last + 2)
        drive_cmd(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, DEPTH - 1)),
                  int'($urandom_range(0, DEPTH - 1)));
      inst_v = (c >= 2) && (c <= last);
      idx    = c - 2;
      exp_inst.mode = 2'(md);
      if (idx == 0) begin
        exp_inst.opcode = PE_OP_OPCODE;  exp_inst.value = PE_CLR_VALUE;
      end else if (idx <= n) begin
        exp_inst.opcode = PE_OP_OPCODE;  exp_inst.value = PE_MAC_VALUE;
      end else if (sh != 0 && idx == n + 1) begin
        exp_inst.opcode = PE_RND_OPCODE; exp_inst.value = 8'(sh);
      end else begin
        exp_inst.opcode = PE_OP_OPCODE;  exp_inst.value = PE_OUT_VALUE;
      end
      check("pe_inst_valid", 64'(pe_inst_valid), 64'(inst_v));
      if (inst_v) check("pe_inst", 64'(pe_inst), 64'(exp_inst));
      rd_v = (c >= 2) && (c <= n + 1);
      check("vec_rd_en", 64'(vec_rd_en), 64'(rd_v));
      check("mat_rd_en", 64'(mat_rd_en), 64'(rd_v));
      if (rd_v) begin
        check("vec_rd_addr", 64'(vec_rd_addr), 64'((vb + c - 2) % DEPTH));
        check("mat_rd_addr", 64'(mat_rd_addr), 64'((mb + c - 2) % DEPTH));
      end
      mac_v = (c >= 3) && (c <= n + 2);
      check("pe_vector_input", 64'(pe_vector_input),
            mac_v ? 64'(vec_mem[(vb + c - 3) % DEPTH]) : 64'd0);
      check("pe_matrix_input", 64'(pe_matrix_input),
            mac_v ? 64'(mat_mem[(mb + c - 3) % DEPTH]) : 64'd0);
      check("busy", 64'(busy), 64'(c <= last + 1));
      check("cmd_ready", 64'(cmd_ready), 64'(c == last + 2));
      check("result_valid", 64'(result_valid), 64'(c == last + 2));
      if (c == last + 2) check("result_data", 64'(result_data), 64'(exp_res));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    drive_cmd(0, 0, 0, 0, 0);
    cmd_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      vec_mem[i] = $urandom;
      mat_mem[i] = $urandom;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_inst_valid", 64'(pe_inst_valid), 64'd0);
    check("rst_inst", 64'(pe_inst), 64'd0);
    check("rst_rd_en", 64'({vec_rd_en, mat_rd_en}), 64'd0);
    check("rst_rd_addr", 64'({vec_rd_addr, mat_rd_addr}), 64'd0);
    check("rst_operands", {pe_vector_input, pe_matrix_input}, 64'd0);
    check("rst_result_valid", 64'(result_valid), 64'd0);
    check("rst_result_data", 64'(result_data), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 64'(cmd_ready), 64'd1);

    // Mode 2, N=3, shift=0: 2*5+3*6+4*7.
    vec_mem[0] = 32'd2; vec_mem[1] = 32'd3; vec_mem[2] = 32'd4;
    mat_mem[0] = 32'd5; mat_mem[1] = 32'd6; mat_mem[2] = 32'd7;
    run_cmd(3, 0, 2, 0, 0, 1'b0);
    check("t1_result", 64'(result_data), 64'd56);

    // Mode 0, four 8-bit lanes, RND by 1.
    vec_mem[0] = 32'h0403_0201; vec_mem[1] = 32'h0403_0201;
    mat_mem[0] = 32'h0a0a_0a0a; mat_mem[1] = 32'h0a0a_0a0a;
    run_cmd(2, 1, 0, 0, 0, 1'b0);
    check("t2_result", 64'(result_data), 64'h281e_140a);

    // N=0, no RND: CLR and OUT back-to-back, no strobes.
    run_cmd(0, 0, 3, 5, 9, 1'b0);
    check("t3_result", 64'(result_data), 64'd0);

    // Address wrap.
    run_cmd(3, 2, 1, 1023, 1022, 1'b0);

    // Reset in cycle 4 of an N=10 command.
    drive_cmd(10, 3, 2, 100, 200);
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_inst_valid", 64'(pe_inst_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("midrst_rd_en", 64'(vec_rd_en), 64'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      check("postrst_inst_valid", 64'(pe_inst_valid), 64'd0);
      check("postrst_result_valid", 64'(result_valid), 64'd0);
      check("postrst_cmd_ready", 64'(cmd_ready), 64'd1);
    end
    run_cmd(4, 1, 1, 300, 400, 1'b0);

    // cmd_valid held through busy with changing fields; back-to-back results.
    run_cmd(2, 0, 0, 10, 20, 1'b1);
    run_cmd(5, 2, 2, 30, 40, 1'b1);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("hold_end_idle", 64'(busy), 64'd0);

    // Randomized commands, sometimes chained with cmd_valid held high.
    for (int t = 0; t < 30; t++) begin
      run_cmd(int'($urandom_range(0, 20)),
              ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 7)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, DEPTH - 1)),
              int'($urandom_range(0, DEPTH - 1)), 1'($urandom_range(0, 1)));
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    check("final_idle", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
